// File: rtl/watchdog_sequencer.sv
// rtl/watchdog_sequencer.sv - arms the watchdog, debounces its match event, retries on timeout, reports one verdict per check
// Optional WDOG_SEQ_STATS_EN: implements saturating pass/fail tallies; otherwise the tally ports read 0.
module watchdog_sequencer #(
    parameter int MAX_RETRIES = 3,
    parameter int MATCH_HOLD  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_timeout_event,
    input  logic             i_signal_match_event,
    output logic             o_wdog_clr,
    output logic             o_timer_en,
    output logic             o_busy,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_result_pass,
    output logic [3:0]       o_result_tries,
    output logic [CNT_W-1:0] o_pass_count,
    output logic [CNT_W-1:0] o_fail_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam logic [7:0] HOLD_TGT  = 8'(MATCH_HOLD);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [3:0]  tries_q, tries_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  hold_inc;
    logic [1:0]  settle_q, settle_d;
    logic        pass_d;
    logic        handshake;

    assign hold_inc  = hold_q + 8'd1;
    assign handshake = o_result_valid && i_result_ready;

    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        hold_d   = hold_q;
        settle_d = settle_q;
        pass_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    tries_d = 4'd1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = i_abort ? S_IDLE : S_SETTLE;
            end
            S_SETTLE: begin
                // Watchdog outputs are registered, so they lag the clear by two cycles.
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (settle_q == 2'd1) begin
                    state_d = S_WAIT;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            S_WAIT: begin
                hold_d = i_signal_match_event ? hold_inc : 8'd0;
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (i_signal_match_event && hold_inc == HOLD_TGT) begin
                    pass_d  = 1'b1;
                    state_d = S_REPORT;
                end else if (i_timeout_event) begin
                    if (tries_q <= RETRY_MAX) begin
                        tries_d = tries_q + 4'd1;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_CLEAR) begin
            hold_d   = 8'd0;
            settle_d = 2'd0;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            tries_q        <= 4'd0;
            hold_q         <= 8'd0;
            settle_q       <= 2'd0;
            o_wdog_clr     <= 1'b0;
            o_timer_en     <= 1'b0;
            o_busy         <= 1'b0;
            o_result_valid <= 1'b0;
            o_result_pass  <= 1'b0;
            o_result_tries <= 4'd0;
        end else begin
            state_q        <= state_d;
            tries_q        <= tries_d;
            hold_q         <= hold_d;
            settle_q       <= settle_d;
            o_wdog_clr     <= (state_d == S_CLEAR);
            o_timer_en     <= (state_d == S_WAIT);
            o_busy         <= (state_d != S_IDLE);
            o_result_valid <= (state_d == S_REPORT);
            if (state_d == S_REPORT && state_q != S_REPORT) begin
                o_result_pass  <= pass_d;
                o_result_tries <= tries_q;
            end
        end
    end

`ifdef WDOG_SEQ_STATS_EN
    logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else if (handshake) begin
            if (o_result_pass) begin
                if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            end else begin
                if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_pass_count = pass_cnt_q;
    assign o_fail_count = fail_cnt_q;
`else
    assign o_pass_count = '0;
    assign o_fail_count = '0;
`endif

endmodule

// File: tb/tb_watchdog_sequencer.sv
// tb/tb_watchdog_sequencer.sv - scoreboard bench for watchdog_sequencer with directed check sequences
module tb_watchdog_sequencer;
    localparam int MAX_RETRIES = 3;
    localparam int MATCH_HOLD  = 4;
    localparam int CNT_W       = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_timeout_event = 1'b0;
    logic             i_signal_match_event = 1'b0;
    logic             i_result_ready = 1'b1;
    logic             o_wdog_clr, o_timer_en, o_busy, o_result_valid, o_result_pass;
    logic [3:0]       o_result_tries;
    logic [CNT_W-1:0] o_pass_count, o_fail_count;

    watchdog_sequencer #(
        .MAX_RETRIES(MAX_RETRIES),
        .MATCH_HOLD (MATCH_HOLD),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_start             (i_start),
        .i_abort             (i_abort),
        .i_timeout_event     (i_timeout_event),
        .i_signal_match_event(i_signal_match_event),
        .o_wdog_clr          (o_wdog_clr),
        .o_timer_en          (o_timer_en),
        .o_busy              (o_busy),
        .o_result_valid      (o_result_valid),
        .i_result_ready      (i_result_ready),
        .o_result_pass       (o_result_pass),
        .o_result_tries      (o_result_tries),
        .o_pass_count        (o_pass_count),
        .o_fail_count        (o_fail_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       pass;
        logic [3:0] tries;
    } verdict_t;

    verdict_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int clr_pulses = 0;
    int exp_pass = 0;
    int exp_fail = 0;
    int c0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic verdict_t mk(input logic pass, input logic [3:0] tries);
        verdict_t v;
        v.pass  = pass;
        v.tries = tries;
        return v;
    endfunction

    // Monitor: every accepted verdict must match the oldest expected one.
    always @(negedge i_clk) begin
        verdict_t e;
        if (i_rst_n && o_result_valid && i_result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_verdict: got pass=%0d tries=%0d expected none",
                         o_result_pass, o_result_tries);
            end else begin
                e = exp_q.pop_front();
                check("verdict_pass", int'(o_result_pass), int'(e.pass));
                check("verdict_tries", int'(o_result_tries), int'(e.tries));
            end
        end
    end

    always @(negedge i_clk) if (o_wdog_clr) clr_pulses++;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_check();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_timer_en();
        int n = 0;
        while (!o_timer_en && n < 50) begin
            tick();
            n++;
        end
        check("timer_en_reached", int'(o_timer_en), 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_result_valid && n < 50) begin
            tick();
            n++;
        end
        check("valid_reached", int'(o_result_valid), 1);
    endtask

    task automatic bump_pass();
        exp_pass = (exp_pass == CNT_MAX) ? CNT_MAX : exp_pass + 1;
    endtask

    task automatic check_tallies(input string tag);
`ifdef WDOG_SEQ_STATS_EN
        check({tag, "_pass_count"}, int'(o_pass_count), exp_pass);
        check({tag, "_fail_count"}, int'(o_fail_count), exp_fail);
`else
        check({tag, "_pass_count"}, int'(o_pass_count), 0);
        check({tag, "_fail_count"}, int'(o_fail_count), 0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clr"}, int'(o_wdog_clr), 0);
        check({tag, "_timer_en"}, int'(o_timer_en), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_valid"}, int'(o_result_valid), 0);
        check({tag, "_pass"}, int'(o_result_pass), 0);
        check({tag, "_tries"}, int'(o_result_tries), 0);
        check({tag, "_pass_count"}, int'(o_pass_count), 0);
        check({tag, "_fail_count"}, int'(o_fail_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int pat[7];
        pat = '{1, 1, 0, 1, 1, 1, 1};

        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst_n = 1'b1;
        tick();

        // Basic pass with exact cycle timing
        c0 = clr_pulses;
        exp_q.push_back(mk(1'b1, 4'd1));
        start_check();
        check("c1_clr", int'(o_wdog_clr), 1);
        check("c1_busy", int'(o_busy), 1);
        check("c1_timer_en", int'(o_timer_en), 0);
        tick();
        check("c2_clr", int'(o_wdog_clr), 0);
        tick();
        tick();
        check("c4_timer_en", int'(o_timer_en), 1);
        i_signal_match_event = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("basic_early_valid", int'(o_result_valid), 0);
        end
        tick();
        check("basic_valid", int'(o_result_valid), 1);
        check("basic_timer_off", int'(o_timer_en), 0);
        i_signal_match_event = 1'b0;
        tick();
        check("basic_idle_busy", int'(o_busy), 0);
        check("basic_idle_valid", int'(o_result_valid), 0);
        check("basic_clr_pulses", clr_pulses - c0, 1);
        bump_pass();
        check_tallies("basic");

        // Debounce: a gap restarts the hold count
        exp_q.push_back(mk(1'b1, 4'd1));
        start_check();
        wait_timer_en();
        for (int i = 0; i < 7; i++) begin
            i_signal_match_event = pat[i][0];
            tick();
            check("debounce_valid", int'(o_result_valid), (i == 6) ? 1 : 0);
        end
        i_signal_match_event = 1'b0;
        tick();
        check("debounce_idle", int'(o_busy), 0);
        bump_pass();
        check_tallies("debounce");

        // Retry exhaustion
        c0 = clr_pulses;
        exp_q.push_back(mk(1'b0, 4'd4));
        start_check();
        for (int a = 0; a < 4; a++) begin
            wait_timer_en();
            tick();
            tick();
            i_timeout_event = 1'b1;
            tick();
            i_timeout_event = 1'b0;
        end
        check("retry_valid", int'(o_result_valid), 1);
        tick();
        check("retry_clr_pulses", clr_pulses - c0, 4);
        check("retry_idle", int'(o_busy), 0);
        exp_fail = exp_fail + 1;
        check_tallies("retry");

        // Hold completion and timeout on the same edge: pass wins
        c0 = clr_pulses;
        exp_q.push_back(mk(1'b1, 4'd1));
        start_check();
        wait_timer_en();
        i_signal_match_event = 1'b1;
        repeat (3) tick();
        i_timeout_event = 1'b1;
        tick();
        i_timeout_event = 1'b0;
        i_signal_match_event = 1'b0;
        check("simul_valid", int'(o_result_valid), 1);
        check("simul_clr_now", int'(o_wdog_clr), 0);
        tick();
        check("simul_clr_pulses", clr_pulses - c0, 1);
        check("simul_idle", int'(o_busy), 0);
        bump_pass();
        check_tallies("simul");

        // Abort in WAIT: no verdict, tallies unchanged
        start_check();
        wait_timer_en();
        i_signal_match_event = 1'b1;
        tick();
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        i_signal_match_event = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_timer_en", int'(o_timer_en), 0);
        repeat (5) tick();
        check("abort_no_valid", int'(o_result_valid), 0);
        check_tallies("abort");

        // Backpressure: verdict held stable for 10 cycles
        i_result_ready = 1'b0;
        exp_q.push_back(mk(1'b1, 4'd1));
        start_check();
        wait_timer_en();
        i_signal_match_event = 1'b1;
        wait_valid();
        i_signal_match_event = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", int'(o_result_valid), 1);
            check("bp_pass", int'(o_result_pass), 1);
            check("bp_tries", int'(o_result_tries), 1);
            tick();
        end
        check_tallies("bp_before");
        i_result_ready = 1'b1;
        tick();
        check("bp_idle_valid", int'(o_result_valid), 0);
        bump_pass();
        check_tallies("bp_after");

        // Asynchronous reset mid-WAIT
        start_check();
        wait_timer_en();
        i_signal_match_event = 1'b1;
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        i_signal_match_event = 1'b0;
        tick();
        i_rst_n = 1'b1;
        exp_pass = 0;
        exp_fail = 0;
        tick();

        // Tally saturation: five passes into a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(mk(1'b1, 4'd1));
            start_check();
            wait_timer_en();
            i_signal_match_event = 1'b1;
            wait_valid();
            i_signal_match_event = 1'b0;
            tick();
            bump_pass();
        end
        check_tallies("saturate");

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
